// File: rtl/serial_compare_ctrl.sv
// Serial LSB-first compare of two operands through an external comparator8 cascade; SERIAL_CMP_SIGNED_EN selects two's complement.
// Latency: done pulses len+1 cycles after an accepted start; no backpressure, start is ignored while busy or done.
module serial_compare_ctrl #(
  parameter int MAX_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [8*MAX_BYTES-1:0] op_a,
  input  logic [8*MAX_BYTES-1:0] op_b,
  input  logic [2:0]             len,
  output logic [7:0]             cmp_a,
  output logic [7:0]             cmp_b,
  output logic                   cmp_l,
  output logic                   cmp_e,
  output logic                   cmp_g,
  input  logic                   cmp_lt,
  input  logic                   cmp_eq,
  input  logic                   cmp_gt,
  output logic                   busy,
  output logic                   done,
  output logic                   res_lt,
  output logic                   res_eq,
  output logic                   res_gt,
  output logic                   err
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state;
  logic [8*MAX_BYTES-1:0] sh_a;
  logic [8*MAX_BYTES-1:0] sh_b;
  logic [2:0]             idx;
  logic [2:0]             last_idx;
  logic [2:0]             casc;
  logic [2:0]             res;
  logic [2:0]             len_eff;
  logic [2:0]             triple;
  logic                   one_hot;
  logic                   is_last;
  logic [7:0]             msb_flip;

  assign len_eff = (len == 3'd0 || len > MAX_LEN) ? MAX_LEN : len;
  assign triple  = {cmp_lt, cmp_eq, cmp_gt};
  assign one_hot = (triple == 3'b100) || (triple == 3'b010) || (triple == 3'b001);
  assign is_last = (idx == last_idx);

`ifdef SERIAL_CMP_SIGNED_EN
  // Flipping the sign bit of the top byte maps two's complement onto unsigned order.
  assign msb_flip = {is_last, 7'b0};
`else
  assign msb_flip = 8'h00;
`endif

  always_comb begin
    cmp_a = 8'h00;
    cmp_b = 8'h00;
    {cmp_l, cmp_e, cmp_g} = 3'b010;
    if (state == RUN) begin
      cmp_a = sh_a[7:0] ^ msb_flip;
      cmp_b = sh_b[7:0] ^ msb_flip;
      {cmp_l, cmp_e, cmp_g} = casc;
    end
  end

  assign {res_lt, res_eq, res_gt} = res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh_a     <= '0;
      sh_b     <= '0;
      idx      <= 3'd0;
      last_idx <= 3'd0;
      casc     <= 3'b010;
      res      <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a     <= op_a;
            sh_b     <= op_b;
            idx      <= 3'd0;
            last_idx <= len_eff - 3'd1;
            casc     <= 3'b010;
            res      <= 3'b000;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          casc <= triple;
          sh_a <= sh_a >> 8;
          sh_b <= sh_b >> 8;
          idx  <= idx + 3'd1;
          if (!one_hot) err <= 1'b1;
          if (is_last) begin
            res   <= triple;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          idx   <= 3'd0;
          casc  <= 3'b010;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl with a behavioural comparator8 stage and an integer-level reference model.
module tb_serial_compare_ctrl;

`ifdef SERIAL_CMP_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] op_a, op_b;
  logic [2:0]  len;
  logic [7:0]  cmp_a, cmp_b;
  logic        cmp_l, cmp_e, cmp_g;
  logic        cmp_lt, cmp_eq, cmp_gt;
  logic        busy, done, res_lt, res_eq, res_gt, err;

  logic        force_en;
  logic [2:0]  cmp_t;

  int vectors = 0;
  int miscompares = 0;

  int         obs_done_cyc;
  int         obs_busy_cnt;
  logic [2:0] obs_res;
  logic       obs_err;
  logic [7:0] obs_a [16];
  logic [7:0] obs_b [16];

  always #5 clk = ~clk;

  serial_compare_ctrl #(.MAX_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .len(len),
    .cmp_a(cmp_a), .cmp_b(cmp_b), .cmp_l(cmp_l), .cmp_e(cmp_e), .cmp_g(cmp_g),
    .cmp_lt(cmp_lt), .cmp_eq(cmp_eq), .cmp_gt(cmp_gt),
    .busy(busy), .done(done), .res_lt(res_lt), .res_eq(res_eq), .res_gt(res_gt), .err(err)
  );

  // comparator8: the current (more significant) byte decides unless equal
  always_comb begin
    if (cmp_a < cmp_b)      cmp_t = 3'b100;
    else if (cmp_a > cmp_b) cmp_t = 3'b001;
    else                    cmp_t = {cmp_l, cmp_e, cmp_g};
    if (force_en) cmp_t = 3'b110;
  end
  assign {cmp_lt, cmp_eq, cmp_gt} = cmp_t;

  function automatic int eff_len(input logic [2:0] l);
    return (l == 3'd0 || l > 3'd4) ? 4 : int'(l);
  endfunction

  function automatic logic [2:0] model(input logic [31:0] a, input logic [31:0] b, input int n);
    longint va, vb;
    int bits;
    bits = 8 * n;
    va = longint'(a) & ((longint'(1) << bits) - 1);
    vb = longint'(b) & ((longint'(1) << bits) - 1);
    if (SIGNED) begin
      if (((va >> (bits - 1)) & 1) == 1) va = va - (longint'(1) << bits);
      if (((vb >> (bits - 1)) & 1) == 1) vb = vb - (longint'(1) << bits);
    end
    if (va < vb) return 3'b100;
    if (va > vb) return 3'b001;
    return 3'b010;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [31:0] v, input int k, input int n);
    logic [7:0] bv;
    bv = 8'(v >> (8 * k));
    if (SIGNED && k == n - 1) bv[7] = ~bv[7];
    return bv;
  endfunction

  // Drives one compare, records what the DUT showed, and leaves the DUT in IDLE.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [2:0] l,
                        input int force_cyc, input int start_cyc, input bit start_in_done);
    start = 1'b1; op_a = a; op_b = b; len = l;
    @(posedge clk); #1;
    start = 1'b0; op_a = $urandom; op_b = $urandom; len = 3'($urandom);
    obs_done_cyc = 0; obs_busy_cnt = 0; obs_res = 3'b000; obs_err = 1'b0;
    for (int c = 1; c <= 12 && obs_done_cyc == 0; c++) begin
      if (busy) begin
        obs_busy_cnt++;
        obs_a[c] = cmp_a;
        obs_b[c] = cmp_b;
      end
      if (done) begin
        obs_done_cyc = c;
        obs_res = {res_lt, res_eq, res_gt};
        obs_err = err;
      end else begin
        if (c == force_cyc) force_en = 1'b1;
        if (c == start_cyc) start = 1'b1;
        @(posedge clk); #1;
        force_en = 1'b0;
        start = 1'b0;
      end
    end
    if (start_in_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; len = 3'd0; force_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, err, res_lt, res_eq, res_gt} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_flags: got busy,done,err,res=%b required 000000", {busy, done, err, res_lt, res_eq, res_gt});
    end
    vectors++;
    if ({cmp_a, cmp_b, cmp_l, cmp_e, cmp_g} !== {16'h0, 3'b010}) begin
      miscompares++;
      $display("FAIL reset_cmp_outputs: got a=%h b=%h leg=%b required 00 00 010", cmp_a, cmp_b, {cmp_l, cmp_e, cmp_g});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_compare(input string name, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] l);
    int n;
    logic [2:0] exp;
    n = eff_len(l);
    exp = model(a, b, n);
    launch(a, b, l, 0, 0, 1'b0);
    vectors++;
    if (obs_res !== exp) begin
      miscompares++;
      $display("FAIL %s_result: got %b required %b (a=%h b=%h len=%0d)", name, obs_res, exp, a, b, l);
    end
    vectors++;
    if (obs_done_cyc != n + 1 || obs_busy_cnt != n) begin
      miscompares++;
      $display("FAIL %s_timing: got done_cycle=%0d busy_cycles=%0d required %0d %0d", name, obs_done_cyc, obs_busy_cnt, n + 1, n);
    end
    vectors++;
    if (obs_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_err: got %b required 0", name, obs_err);
    end
    for (int k = 0; k < n && k < obs_busy_cnt; k++) begin
      vectors++;
      if (obs_a[k + 1] !== exp_byte(a, k, n) || obs_b[k + 1] !== exp_byte(b, k, n)) begin
        miscompares++;
        $display("FAIL %s_byte%0d: got a=%h b=%h required %h %h", name, k, obs_a[k + 1], obs_b[k + 1], exp_byte(a, k, n), exp_byte(b, k, n));
      end
    end
    vectors++;
    if ({res_lt, res_eq, res_gt} !== exp || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_hold: got res=%b busy=%b required %b 0", name, {res_lt, res_eq, res_gt}, busy, exp);
    end
  endtask

  task automatic test_directed;
    check_compare("equal4", 32'h12345678, 32'h12345678, 3'd4);
    check_compare("msb_gt", 32'h00000201, 32'h000001FF, 3'd2);
    check_compare("lsb_lt", 32'h00000100, 32'h00000101, 3'd2);
    check_compare("sign_byte", 32'h00000080, 32'h00000001, 3'd1);
    check_compare("len0", 32'h80000000, 32'h7FFFFFFF, 3'd0);
    check_compare("len7", 32'h01020304, 32'h01020305, 3'd7);
  endtask

  task automatic test_random;
    logic [31:0] a, b, m;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      m = {{8{1'($urandom)}}, {8{1'($urandom)}}, {8{1'($urandom)}}, {8{1'($urandom)}}};
      b = (a & ~m) | ($urandom & m);
      check_compare("random", a, b, 3'($urandom_range(0, 7)));
    end
  endtask

  task automatic test_start_ignored;
    launch(32'h00AA0000, 32'h00BB0000, 3'd3, 0, 2, 1'b1);
    vectors++;
    if (obs_done_cyc != 4 || obs_res !== 3'b100) begin
      miscompares++;
      $display("FAIL start_in_run: got done_cycle=%0d res=%b required 4 100", obs_done_cyc, obs_res);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done_idle: got busy=%b required 0", busy);
    end
    @(posedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL start_in_done_noqueue: got busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_err;
    launch(32'h40000000, 32'h10000000, 3'd4, 2, 0, 1'b0);
    vectors++;
    if (obs_err !== 1'b1 || obs_res !== 3'b001) begin
      miscompares++;
      $display("FAIL err_set: got err=%b res=%b required 1 001", obs_err, obs_res);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got %b required 1", err);
    end
    start = 1'b1; op_a = 32'h5; op_b = 32'h5; len = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL err_clear: got err=%b busy=%b required 0 1", err, busy);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_run;
    int seen;
    start = 1'b1; op_a = 32'h11111111; op_b = 32'h22222222; len = 3'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ({busy, done, err, res_lt, res_eq, res_gt} !== 6'b0 || {cmp_a, cmp_l, cmp_e, cmp_g} !== 11'b010) begin
      miscompares++;
      $display("FAIL reset_mid_run: got flags=%b cmp_a=%h leg=%b required 000000 00 010",
               {busy, done, err, res_lt, res_eq, res_gt}, cmp_a, {cmp_l, cmp_e, cmp_g});
    end
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d active cycles required 0", seen);
    end
    check_compare("after_reset", 32'hDEADBEEF, 32'hDEADBEEE, 3'd4);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_err();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
